// File: rtl/roberts_window_buffer_pkg.sv
// Shared defaults and state encoding for the Roberts cross 2x2 window generator.
package roberts_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int ROWS_DEF  = 242;
  localparam int COLS_DEF  = 247;

  typedef enum logic {
    FIRST_ROW = 1'b0,
    BODY      = 1'b1
  } state_t;

endpackage

// File: rtl/roberts_window_buffer_line_buffer.sv
// One image line of pixel storage: combinational read, write on the clock edge.
module roberts_line_buffer #(
  parameter int DEPTH  = 247,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic              we,
  output logic [PIX_W-1:0]  rdata
);

  // Left unreset: row 0 of every frame fills the line before any read is used.
  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/roberts_window_buffer.sv
// Raster-order pixel stream in, 2x2 neighbourhoods with top-left coordinates out.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   FIRST_ROW | accepting row 0; only fills the line buffer, no windows
//   BODY      | rows 1..ROWS-1; each accept with col>=1 emits one window
module roberts_window_buffer
  import roberts_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIX_W-1:0]         in_pixel,
  input  logic                     in_sof,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [PIX_W-1:0]         win_p00,
  output logic [PIX_W-1:0]         win_p01,
  output logic [PIX_W-1:0]         win_p10,
  output logic [PIX_W-1:0]         win_p11,
  output logic [$clog2(ROWS)-1:0]  win_row,
  output logic [$clog2(COLS)-1:0]  win_col,
  output logic                     win_last,
  output logic                     sof_err
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_t           state_q, state_d, state_eff;
  logic [ROW_W-1:0] row_q, row_d, row_eff;
  logic [COL_W-1:0] col_q, col_d, col_eff;
  logic             accept, at_origin, row_end, frame_end, load_win;
  logic [PIX_W-1:0] top_pix, top_prev_q, left_prev_q;

  assign in_ready  = !win_valid || win_ready;
  assign accept    = in_valid && in_ready;
  assign at_origin = (row_q == '0) && (col_q == '0);

  // A start-of-frame pixel is always position (0,0), whatever the counters say.
  always_comb begin
    row_eff   = row_q;
    col_eff   = col_q;
    state_eff = state_q;
    if (in_sof) begin
      row_eff   = '0;
      col_eff   = '0;
      state_eff = FIRST_ROW;
    end
  end

  assign row_end   = (col_eff == COL_LAST);
  assign frame_end = row_end && (row_eff == ROW_LAST);
  assign load_win  = accept && (state_eff == BODY) && (col_eff != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIRST_ROW;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_eff)
        FIRST_ROW: state_d = row_end ? BODY : FIRST_ROW;
        BODY:      state_d = frame_end ? FIRST_ROW : BODY;
        default:   state_d = FIRST_ROW;
      endcase
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (row_end) begin
        col_d = '0;
        row_d = frame_end ? '0 : row_eff + ROW_W'(1);
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  roberts_line_buffer #(
    .DEPTH (COLS),
    .PIX_W (PIX_W),
    .ADDR_W(COL_W)
  ) u_line (
    .clk  (clk),
    .addr (col_eff),
    .wdata(in_pixel),
    .we   (accept),
    .rdata(top_pix)
  );

  // top_pix still carries row-1 here; the write of in_pixel lands on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_prev_q  <= '0;
      left_prev_q <= '0;
    end else if (accept) begin
      top_prev_q  <= top_pix;
      left_prev_q <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_p00   <= '0;
      win_p01   <= '0;
      win_p10   <= '0;
      win_p11   <= '0;
      win_row   <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
    end else if (load_win) begin
      win_valid <= 1'b1;
      win_p00   <= top_prev_q;
      win_p01   <= top_pix;
      win_p10   <= left_prev_q;
      win_p11   <= in_pixel;
      win_row   <= row_eff - ROW_W'(1);
      win_col   <= col_eff - COL_W'(1);
      win_last  <= frame_end;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sof_err <= 1'b0;
    end else if (accept && in_sof && !at_origin) begin
      sof_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_roberts_window_buffer.sv
// Directed bench: 3x4 frames with hand-derived windows plus a full-size random frame.
module tb_roberts_window_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, in_sof = 1'b0, win_ready = 1'b1;
  logic [7:0] in_pixel = '0;
  logic       in_ready, win_valid, win_last, sof_err;
  logic [7:0] win_p00, win_p01, win_p10, win_p11;
  logic [1:0] win_row, win_col;

  logic       in_valid2 = 1'b0, in_sof2 = 1'b0, win_ready2 = 1'b1;
  logic [7:0] in_pixel2 = '0;
  logic       in_ready2, win_valid2, win_last2, sof_err2;
  logic [7:0] win_p00_2, win_p01_2, win_p10_2, win_p11_2;
  logic [7:0] win_row2, win_col2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [36:0] q[$];
  int          k2 = 0;
  localparam int BR = 242, BC = 247, BN = 241 * 246;
  logic [7:0]  frame [BR*BC];

  always #5 clk = ~clk;

  roberts_window_buffer #(.ROWS(3), .COLS(4), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_p00(win_p00), .win_p01(win_p01), .win_p10(win_p10), .win_p11(win_p11),
    .win_row(win_row), .win_col(win_col), .win_last(win_last), .sof_err(sof_err)
  );

  roberts_window_buffer dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_pixel(in_pixel2), .in_sof(in_sof2),
    .win_valid(win_valid2), .win_ready(win_ready2),
    .win_p00(win_p00_2), .win_p01(win_p01_2), .win_p10(win_p10_2), .win_p11(win_p11_2),
    .win_row(win_row2), .win_col(win_col2), .win_last(win_last2), .sof_err(sof_err2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [36:0] exp_win(input int r, input int c);
    return {8'(10*r + c), 8'(10*r + c + 1), 8'(10*(r+1) + c), 8'(10*(r+1) + c + 1),
            2'(r), 2'(c), (r == 1 && c == 2)};
  endfunction

  function automatic int grad(input logic [7:0] a, b, c, d);
    int s;
    s = int'(a) - int'(d) + int'(b) - int'(c);
    if (s < 0) s = -s;
    if (s > 255) s = 255;
    return s;
  endfunction

  // Windows are recorded at the negedge before the handshake edge.
  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready)
      q.push_back({win_p00, win_p01, win_p10, win_p11, win_row, win_col, win_last});
    if (rst_n && win_valid && !win_ready)
      chk("bp_in_ready", 64'(in_ready), 64'd0);
  end

  always @(negedge clk) begin
    if (rst_n && win_valid2 && win_ready2) begin
      if (k2 < BN) begin
        int r, c;
        logic [7:0] a, b, e, d;
        r = k2 / 246;
        c = k2 % 246;
        a = frame[r*BC + c];
        b = frame[r*BC + c + 1];
        e = frame[(r+1)*BC + c];
        d = frame[(r+1)*BC + c + 1];
        chk("big_win", {win_p00_2, win_p01_2, win_p10_2, win_p11_2, win_row2, win_col2, win_last2},
            {a, b, e, d, 8'(r), 8'(c), (k2 == BN - 1)});
        chk("big_grad", 64'(grad(win_p00_2, win_p01_2, win_p10_2, win_p11_2)),
            64'(grad(a, b, e, d)));
      end
      k2++;
    end
  end

  task automatic push_pixel(input logic [7:0] pix, input bit sof, input bit rnd);
    bit done;
    int guard;
    done = 0;
    guard = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = 1'b1;
      in_pixel  = pix;
      in_sof    = sof;
      #1;
      done = in_ready;
      guard++;
      if (!done && guard > 200) begin
        chk("push_timeout", 64'd1, 64'd0);
        done = 1;
      end
    end
  endtask

  task automatic send_frame(input bit rnd, input bit sof_first, input int npix);
    for (int i = 0; i < npix; i++)
      push_pixel(8'(10*(i/4) + i%4), sof_first && (i == 0), rnd);
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    win_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag);
    logic [36:0] w;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) begin
        w = (q.size() > 0) ? q.pop_front() : '1;
        chk(tag, 64'(w), 64'(exp_win(r, c)));
      end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_win_valid", 64'(win_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sof_err", 64'(sof_err), 64'd0);
    chk("rst_outputs", {win_p00, win_p01, win_p10, win_p11, win_row, win_col, win_last}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // full-rate frame
    send_frame(0, 1, 12);
    drain();
    chk("t1_count", 64'(q.size()), 64'd6);
    check_frame("t1_win");
    q.delete();

    // random downstream stalls
    send_frame(1, 1, 12);
    drain();
    chk("t2_count", 64'(q.size()), 64'd6);
    check_frame("t2_win");
    q.delete();

    // back-to-back frames
    send_frame(0, 1, 12);
    send_frame(0, 1, 12);
    drain();
    chk("t3_count", 64'(q.size()), 64'd12);
    chk("t3_sof_err", 64'(sof_err), 64'd0);
    check_frame("t3_win_a");
    check_frame("t3_win_b");
    q.delete();

    // in_sof on 7th pixel restarts the frame
    send_frame(0, 1, 6);
    send_frame(0, 1, 12);
    drain();
    chk("t4_sof_err", 64'(sof_err), 64'd1);
    chk("t4_count", 64'(q.size()), 64'd7);
    chk("t4_partial", 64'(q.size() > 0 ? q.pop_front() : '1), 64'(exp_win(0, 0)));
    check_frame("t4_win");
    q.delete();

    // reset mid row 1 with a window held by backpressure
    send_frame(0, 1, 6);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    win_ready = 1'b0;
    #1;
    chk("t5_held", 64'(win_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(win_valid), 64'd0);
    chk("t5_rst_outputs", {win_p00, win_p01, win_p10, win_p11, win_row, win_col, win_last}, 64'd0);
    chk("t5_rst_sof_err", 64'(sof_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    win_ready = 1'b1;
    q.delete();
    send_frame(0, 0, 12);
    drain();
    chk("t5_count", 64'(q.size()), 64'd6);
    check_frame("t5_win");
    q.delete();

    // full-size random frame against golden
    for (int i = 0; i < BR*BC; i++) frame[i] = 8'($urandom_range(0, 255));
    frame[0] = 8'd255;
    frame[1] = 8'd255;
    frame[BC] = 8'd0;
    frame[BC+1] = 8'd0;
    for (int i = 0; i < BR*BC; i++) begin
      @(posedge clk);
      #1;
      in_valid2 = 1'b1;
      in_pixel2 = frame[i];
      in_sof2   = (i == 0);
    end
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    in_sof2   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("big_count", 64'(k2), 64'(BN));
    chk("big_sof_err", 64'(sof_err2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/roberts_window_buffer.md
# roberts_window_buffer

Streaming 2x2 window generator that sits directly upstream of the Roberts cross edge kernel. It accepts a raster-order 8-bit pixel stream over a valid/ready handshake and buffers one image line. For every pixel position whose right and lower neighbours exist, it emits the 2x2 neighbourhood together with its coordinates. The downstream kernel computes |(p00-p11)+(p01-p10)| per window and zeroes the frame border using the supplied coordinates.

## Interface
Parameters:
- ROWS, 242, image height in pixels (≥2)
- COLS, 247, image width in pixels (≥2)
- PIX_W, 8, pixel width in bits

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel present on in_pixel
- in_ready  out  1  block can accept a pixel this cycle
- in_pixel  in  PIX_W  raster-order pixel
- in_sof  in  1  qualifies the accepted pixel as frame start (0,0)
- win_valid  out  1  window present
- win_ready  in  1  downstream accepts the window
- win_p00, win_p01, win_p10, win_p11  out  PIX_W each  pixels at (r,c), (r,c+1), (r+1,c), (r+1,c+1)
- win_row  out  $clog2(ROWS)  r, the window's top-left row
- win_col  out  $clog2(COLS)  c, the window's top-left column
- win_last  out  1  final window of the frame, at (ROWS-2, COLS-2)
- sof_err  out  1  sticky flag: in_sof seen while counters were not at (0,0)

## Operation
- Accept condition: in_valid && in_ready. in_ready = !win_valid || win_ready. This is a single output register with no skid buffer.
- Counters col (0..COLS-1) and row (0..ROWS-1) track the position of the next accepted pixel.
  - Each accept increments col.
  - At COLS-1, col wraps to 0 and row increments.
  - At (ROWS-1, COLS-1), both counters wrap to (0,0).
- State machine:
  - FIRST_ROW: row==0; no windows are emitted. Moves to BODY on the accept at (0, COLS-1).
  - BODY: rows 1..ROWS-1. Returns to FIRST_ROW on the accept at (ROWS-1, COLS-1).
- Line buffer: COLS x PIX_W, asynchronous read, synchronous write at address col. On every accept:
  - top = line[col], which still holds row-1 data.
  - line[col] is then written with in_pixel.
  - top_prev <= top.
  - left_prev <= in_pixel.
- Window emission: an accept in BODY with col≥1 loads the output register as follows:
  - p00 = top_prev, p01 = top, p10 = left_prev, p11 = in_pixel
  - win_row = row-1, win_col = col-1
  - win_last = (row==ROWS-1 && col==COLS-1)
  - Each frame yields exactly (ROWS-1)*(COLS-1) windows.
- in_sof handling:
  - An accept with in_sof treats the pixel as (0,0) regardless of the counters.
  - If the counters were not at (0,0), sof_err is set (sticky until reset), state is forced to FIRST_ROW, and no window is emitted for that pixel.
- win_valid clears on win_ready unless a new window loads in the same cycle. In that case it stays 1 with the new data.

## Timing
- Reset values:
  - in_ready=1 (derived), win_valid=0, win_p*=0, win_row=0, win_col=0, win_last=0, sof_err=0
  - counters=0, state=FIRST_ROW, top_prev=0, left_prev=0
  - Line buffer contents are not reset; row 0 overwrites them before any read is used.
- Latency: a window is valid the cycle after the accept of its p11 pixel.
- Throughput: one pixel/window per cycle when win_ready is held high.
- Backpressure: while win_valid && !win_ready, in_ready=0. Counters, line buffer and output register all hold.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously). The next accepted pixel is treated as (0,0).
- Column 0 accepts in BODY update the line buffer, top_prev and left_prev but emit nothing.

## Structure
- Package roberts_pkg holds:
  - PIX_W default
  - default ROWS/COLS
  - state enum {FIRST_ROW, BODY}
- Sub-module roberts_line_buffer: a single-line register array with async read and sync write (addr, wdata, we, rdata). The top level holds the counters, FSM, top_prev/left_prev and the output register.

## Test plan
- ROWS=3, COLS=4, pixel=10*r+c, win_ready=1: exactly 6 windows.
  - First window: p00=0, p01=1, p10=10, p11=11 at (0,0).
  - Last window: p00=12, p01=13, p10=22, p11=23 at (1,2), with win_last=1 only on that window.
- Same stream with win_ready toggled on a random 50% duty: the window sequence is identical to the previous case. in_ready=0 whenever win_valid && !win_ready, and no window is dropped or duplicated.
- Two back-to-back frames with in_sof on each (0,0): 12 windows total, sof_err remains 0, and the second frame's first window is (0,0).
- in_sof asserted on the 7th pixel of a frame: sof_err=1 and no window for that pixel. The subsequent frame produces the correct 6 windows.
- rst_n pulsed low mid-row-1: win_valid drops immediately and all outputs go to 0. A fresh frame after release produces the correct 6 windows.
- Default 242x247, random pixels, compared against a golden model: 241*246 = 59286 windows. A 2x2 gradient checker reproduces the golden |(p00-p11)+(p01-p10)| values, clamped to 255.
